z80_bus_bridge: RTL and testbench



---
 rtl/z80_bus_pkg.sv | 25 ++
 rtl/z80_bus_bridge.sv | 165 ++++++++++++++++
 tb/tb_z80_bus_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_bus_pkg.sv
// Shared encodings for the Z80 bus bridge: transaction kinds, FSM states and
// the reset value of the CPU data-in bus.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    MEM_RD = 2'd0,
    MEM_WR = 2'd1,
    IO_RD  = 2'd2,
    IO_WR  = 2'd3
  } bus_kind_e;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIFY,
    REQ,
    DONE
  } bridge_state_e;

  localparam logic [7:0] DIN_RESET = 8'hFF;

  function automatic logic kind_is_read(input bus_kind_e kind);
    return (kind == MEM_RD) || (kind == IO_RD);
  endfunction

endpackage

// File: rtl/z80_bus_bridge.sv
// Converts Z80 memory, I/O and interrupt-acknowledge cycles into single-beat
// request/acknowledge transactions, stretching the CPU through nWAIT.
module z80_bus_bridge
  import z80_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nRFSH,
  input  logic [15:0] A,
  input  logic [7:0]  D_out,
  output logic        nWAIT,
  output logic [7:0]  D_in,
  output logic        bus_req,
  output logic [1:0]  bus_kind,
  output logic        bus_inta,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic        bus_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  // The forced completion fires on the edge that would bring the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  bridge_state_e    state_q, state_d;
  bus_kind_e        kind_q, kind_d;
  logic             nWAIT_q, nWAIT_d;
  logic             req_q, req_d;
  logic             inta_q, inta_d;
  logic             tmo_q, tmo_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       din_q, din_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic cycleActive;
  logic classified;

  always_comb begin
    cycleActive = (!nMREQ && nRFSH) || !nIORQ;
    classified  = 1'b0;
    state_d     = state_q;
    kind_d      = kind_q;
    nWAIT_d     = nWAIT_q;
    req_d       = req_q;
    inta_d      = inta_q;
    tmo_d       = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    din_d       = din_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (cycleActive) begin
          state_d = CLASSIFY;
          nWAIT_d = 1'b0;
        end
      end

      CLASSIFY: begin
        // INTA has no read strobe, so it must be recognised before nRD/nWR.
        if (!cycleActive) begin
          state_d = IDLE;
          nWAIT_d = 1'b1;
        end else if (!nIORQ && !nM1) begin
          kind_d     = IO_RD;
          inta_d     = 1'b1;
          classified = 1'b1;
        end else if (!nRD) begin
          if (!nIORQ) kind_d = IO_RD;
          else        kind_d = MEM_RD;
          inta_d     = 1'b0;
          classified = 1'b1;
        end else if (!nWR) begin
          if (!nIORQ) kind_d = IO_WR;
          else        kind_d = MEM_WR;
          inta_d     = 1'b0;
          classified = 1'b1;
        end

        if (classified) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = A;
          wdata_d = D_out;
          cnt_d   = '0;
        end
      end

      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_ack) begin
          if (kind_is_read(kind_q)) din_d = bus_rdata;
          req_d   = 1'b0;
          nWAIT_d = 1'b1;
          state_d = DONE;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          din_d   = TIMEOUT_DATA;
          tmo_d   = 1'b1;
          req_d   = 1'b0;
          nWAIT_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (!cycleActive) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        nWAIT_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      kind_q  <= MEM_RD;
      nWAIT_q <= 1'b1;
      req_q   <= 1'b0;
      inta_q  <= 1'b0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= DIN_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      nWAIT_q <= nWAIT_d;
      req_q   <= req_d;
      inta_q  <= inta_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nWAIT       = nWAIT_q;
  assign D_in        = din_q;
  assign bus_req     = req_q;
  assign bus_kind    = kind_q;
  assign bus_inta    = inta_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_timeout = tmo_q;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Self-checking bench for z80_bus_bridge: directed CPU cycles plus randomized
// transactions compared against a transaction-level reference model.
module tb_z80_bus_bridge;

  localparam int         TMO      = 4;
  localparam logic [7:0] TMO_DATA = 8'hFF;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [15:0] A;
  logic [7:0]  D_out;
  logic        nWAIT;
  logic [7:0]  D_in;
  logic        bus_req;
  logic [1:0]  bus_kind;
  logic        bus_inta;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic        bus_timeout;

  int checks = 0;
  int errors = 0;
  logic [7:0] prevDin;

  z80_bus_bridge #(
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_DATA  (TMO_DATA)
  ) dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .nM1        (nM1),
    .nMREQ      (nMREQ),
    .nIORQ      (nIORQ),
    .nRD        (nRD),
    .nWR        (nWR),
    .nRFSH      (nRFSH),
    .A          (A),
    .D_out      (D_out),
    .nWAIT      (nWAIT),
    .D_in       (D_in),
    .bus_req    (bus_req),
    .bus_kind   (bus_kind),
    .bus_inta   (bus_inta),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_timeout(bus_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic releaseStrobes();
    nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " bus_req"},     32'(bus_req),     32'd0);
    checkOutput({tag, " nWAIT"},       32'(nWAIT),       32'd1);
    checkOutput({tag, " bus_timeout"}, 32'(bus_timeout), 32'd0);
    checkOutput({tag, " bus_kind"},    32'(bus_kind),    32'd0);
    checkOutput({tag, " bus_inta"},    32'(bus_inta),    32'd0);
    checkOutput({tag, " bus_addr"},    32'(bus_addr),    32'd0);
    checkOutput({tag, " bus_wdata"},   32'(bus_wdata),   32'd0);
    checkOutput({tag, " D_in"},        32'(D_in),        32'hFF);
  endtask

  // typ: 0 MEM_RD, 1 MEM_WR, 2 IO_RD, 3 IO_WR, 4 INTA. The target acks during
  // its lat-th request cycle; wrDelay is how many cycles nWR trails the cycle start.
  task automatic applyStimulus(input int typ, input logic [15:0] addr, input logic [7:0] wdata,
                               input logic [7:0] rdata, input int lat, input int wrDelay,
                               input string tag);
    bit isIo, isWr, isInta, expTmo, finished, prevReq;
    int expKind, expCycles, expStart, reqSeen, reqRises, tmoSeen, waitBad, startIdx, extraReq;
    logic [7:0] expDin, dinHold;

    isIo      = (typ >= 2);
    isWr      = (typ == 1) || (typ == 3);
    isInta    = (typ == 4);
    expKind   = (isIo ? 2 : 0) + (isWr ? 1 : 0);
    expCycles = (lat <= TMO) ? lat : TMO;
    expTmo    = (lat > TMO);
    expDin    = expTmo ? TMO_DATA : (isWr ? prevDin : rdata);
    expStart  = (isWr && (wrDelay + 1 > 2)) ? wrDelay + 1 : 2;

    @(negedge CLK);
    A = addr;
    D_out = wdata;
    if (isIo || isInta) nIORQ = 1'b0; else nMREQ = 1'b0;
    if (isInta) nM1 = 1'b0;
    if (!isWr && !isInta) nRD = 1'b0;
    if (isWr && wrDelay == 0) nWR = 1'b0;

    reqSeen = 0; reqRises = 0; tmoSeen = 0; waitBad = 0; startIdx = -1;
    finished = 1'b0; prevReq = 1'b0;
    for (int i = 1; i <= 60 && !finished; i++) begin
      @(negedge CLK);
      if (isWr && i == wrDelay) nWR = 1'b0;
      bus_ack = 1'b0;
      bus_rdata = 8'($urandom);
      if (i == 1) checkOutput({tag, " nWAIT low early"}, 32'(nWAIT), 32'd0);
      if (bus_timeout) tmoSeen++;
      if (bus_req && !prevReq) begin
        reqRises++;
        if (reqRises == 1) begin
          startIdx = i;
          checkOutput({tag, " bus_kind"},  32'(bus_kind),  32'(expKind));
          checkOutput({tag, " bus_inta"},  32'(bus_inta),  32'(isInta));
          checkOutput({tag, " bus_addr"},  32'(bus_addr),  32'(addr));
          checkOutput({tag, " bus_wdata"}, 32'(bus_wdata), 32'(wdata));
        end
      end
      if (bus_req) begin
        reqSeen++;
        if (nWAIT !== 1'b0) waitBad++;
        if (reqSeen == lat) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end
      end
      if (!bus_req && prevReq) begin
        finished = 1'b1;
        checkOutput({tag, " D_in"},  32'(D_in),  32'(expDin));
        checkOutput({tag, " nWAIT released"}, 32'(nWAIT), 32'd1);
      end
      prevReq = bus_req;
    end
    bus_ack = 1'b0;

    checkOutput({tag, " completed"},   32'(finished), 32'd1);
    checkOutput({tag, " req start"},   32'(startIdx), 32'(expStart));
    checkOutput({tag, " req cycles"},  32'(reqSeen),  32'(expCycles));
    checkOutput({tag, " wait in req"}, 32'(waitBad),  32'd0);

    // A stray ack after completion must neither retrigger nor corrupt D_in.
    releaseStrobes();
    extraReq = 0;
    dinHold = D_in;
    for (int i = 0; i < 3; i++) begin
      bus_ack = (i == 1);
      bus_rdata = ~dinHold;
      @(negedge CLK);
      if (bus_req || !nWAIT) extraReq++;
      if (bus_timeout) tmoSeen++;
    end
    bus_ack = 1'b0;
    checkOutput({tag, " req pulses"},    32'(reqRises), 32'd1);
    checkOutput({tag, " quiet after"},   32'(extraReq), 32'd0);
    checkOutput({tag, " timeout pulse"}, 32'(tmoSeen),  32'(expTmo));
    checkOutput({tag, " D_in held"},     32'(D_in),     32'(expDin));
    prevDin = expDin;
  endtask

  initial begin
    int bad;
    bit sawReq;

    nRESET = 1'b0;
    releaseStrobes();
    A = '0; D_out = '0; bus_ack = 1'b0; bus_rdata = '0;
    prevDin = 8'hFF;
    #12;
    checkResetValues("reset");
    @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);

    applyStimulus(0, 16'h1234, 8'h00, 8'hA5, 3, 0, "memRead");
    applyStimulus(1, 16'h4000, 8'h5C, 8'h00, 2, 2, "memWrite");
    applyStimulus(4, 16'h0038, 8'h11, 8'hFF, 1, 0, "inta");
    applyStimulus(2, 16'h00FE, 8'h00, 8'h3C, 1, 0, "ioRead fast");
    applyStimulus(2, 16'h0080, 8'h00, 8'h42, 10, 0, "ioRead timeout");
    applyStimulus(0, 16'hBEEF, 8'h00, 8'h77, TMO, 0, "ack wins");
    applyStimulus(3, 16'h00A0, 8'h99, 8'h00, TMO + 1, 1, "ioWrite timeout");

    // Refresh is not a CPU cycle the bridge serves.
    @(negedge CLK);
    nMREQ = 1'b0; nRFSH = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (bus_req || !nWAIT) bad++;
    end
    releaseStrobes();
    checkOutput("refresh ignored", 32'(bad), 32'd0);

    // Aborted cycle: nMREQ drops and returns before any read/write strobe.
    @(negedge CLK);
    nMREQ = 1'b0;
    @(negedge CLK);
    checkOutput("abort nWAIT low", 32'(nWAIT), 32'd0);
    releaseStrobes();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (bus_req || !nWAIT) bad++;
    end
    checkOutput("abort released", 32'(bad), 32'd0);

    // Reset while an INTA request is outstanding, then a late ack.
    @(negedge CLK);
    A = 16'h5A5A; D_out = 8'hC3; nIORQ = 1'b0; nM1 = 1'b0;
    sawReq = 1'b0;
    for (int i = 0; i < 10 && !sawReq; i++) begin
      @(negedge CLK);
      sawReq = bus_req;
    end
    checkOutput("reset-mid reached req", 32'(sawReq), 32'd1);
    #2;
    nRESET = 1'b0;
    #1;
    checkResetValues("reset-mid");
    releaseStrobes();
    @(negedge CLK);
    @(negedge CLK);
    nRESET = 1'b1;
    bus_ack = 1'b1; bus_rdata = 8'h12;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (bus_req || !nWAIT || D_in !== 8'hFF || bus_timeout) bad++;
    end
    bus_ack = 1'b0;
    checkOutput("late ack ignored", 32'(bad), 32'd0);
    prevDin = 8'hFF;
    applyStimulus(0, 16'h2222, 8'h00, 8'h6D, 2, 0, "after reset");

    for (int n = 0; n < 25; n++) begin
      applyStimulus(int'($urandom_range(0, 4)), 16'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
